// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: data width, the canonical
// NOP encoding and the fetch sequencer state encoding.
package rv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port: valid/ready request channel plus a valid-only
// response channel carrying exactly one word per accepted request.
interface fetch_unit_if;

  logic                     imem_req_valid;
  logic [rv_pkg::XLEN-1:0]  imem_req_addr;
  logic                     imem_req_ready;
  logic                     imem_resp_valid;
  logic [rv_pkg::XLEN-1:0]  imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_unit_skid_buf.sv
// Single-entry {pc, instr} holding register for a response that arrives while
// the IF/ID register is occupied and stalled.
module fetch_skid_buf
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            full,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  logic            full_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] instr_reg;

  // clear wins over load so a redirect can never leave a stale word behind
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      full_reg  <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= NOP_INSTR;
    end else if (load) begin
      full_reg  <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end else if (unload) begin
      full_reg  <= 1'b0;
    end
  end

  assign full  = full_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps one request outstanding to instruction memory
// and presents fetched words through a registered IF/ID stage that holds on stall.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  fetch_unit_if.master        imem,
  output logic [XLEN-1:0]     instruction,
  output logic [XLEN-1:0]     if_pc,
  output logic                if_valid,
  output logic                misaligned
);

  fetch_state_t    state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] instr_reg;
  logic [XLEN-1:0] if_pc_reg;
  logic            if_valid_reg;
  logic            misaligned_reg;

  logic            if_free;
  logic            skid_load;
  logic            skid_unload;
  logic            skid_full;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;

  assign if_free     = !if_valid_reg || !stall;
  assign skid_load   = !redirect && (state_reg == WAIT) && imem.imem_resp_valid && !if_free;
  assign skid_unload = !redirect && (state_reg == HOLD) && !stall;

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (redirect),
    .load_pc    (pc_reg),
    .load_instr (imem.imem_resp_data),
    .full       (skid_full),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

  assign imem.imem_req_valid = (state_reg == REQ);
  assign imem.imem_req_addr  = pc_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= REQ;
      pc_reg         <= RESET_PC;
      instr_reg      <= NOP_INSTR;
      if_pc_reg      <= '0;
      if_valid_reg   <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      misaligned_reg <= 1'b0;
      if (redirect) begin
        pc_reg         <= {redirect_pc[XLEN-1:2], 2'b00};
        if_valid_reg   <= 1'b0;
        instr_reg      <= NOP_INSTR;
        misaligned_reg <= |redirect_pc[1:0];
        // a request already accepted still owes us a response, which must be swallowed
        case (state_reg)
          REQ:     state_reg <= imem.imem_req_ready ? DROP : REQ;
          WAIT:    state_reg <= imem.imem_resp_valid ? REQ : DROP;
          HOLD:    state_reg <= REQ;
          default: state_reg <= DROP;
        endcase
      end else begin
        if (!stall) begin
          if_valid_reg <= 1'b0;
          instr_reg    <= NOP_INSTR;
        end
        case (state_reg)
          REQ: begin
            if (imem.imem_req_ready) state_reg <= WAIT;
          end
          WAIT: begin
            if (imem.imem_resp_valid) begin
              if (if_free) begin
                instr_reg    <= imem.imem_resp_data;
                if_pc_reg    <= pc_reg;
                if_valid_reg <= 1'b1;
                pc_reg       <= pc_reg + 32'd4;
                state_reg    <= REQ;
              end else begin
                state_reg    <= HOLD;
              end
            end
          end
          HOLD: begin
            if (!stall && skid_full) begin
              instr_reg    <= skid_instr;
              if_pc_reg    <= skid_pc;
              if_valid_reg <= 1'b1;
              pc_reg       <= pc_reg + 32'd4;
              state_reg    <= REQ;
            end
          end
          default: begin
            if (imem.imem_resp_valid) state_reg <= REQ;
          end
        endcase
      end
    end
  end

  assign instruction = instr_reg;
  assign if_pc       = if_pc_reg;
  assign if_valid    = if_valid_reg;
  assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios followed by a randomized run against an instruction-stream
// model: every consumed IF/ID word must be the next sequential PC and its memory word.
module tb_fetch_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [31:0] instruction0, if_pc0, instruction1, if_pc1;
  logic        if_valid0, misaligned0, if_valid1, misaligned1;

  fetch_unit_if m0 ();
  fetch_unit_if m1 ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(m0.master), .instruction(instruction0),
    .if_pc(if_pc0), .if_valid(if_valid0), .misaligned(misaligned0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(m1.master), .instruction(instruction1),
    .if_pc(if_pc1), .if_valid(if_valid1), .misaligned(misaligned1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // memory contents: an address-dependent word, distinct from the NOP encoding
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
  endfunction

  logic [31:0] exp_pc, pend_addr, prev_addr, r;
  logic        pending, prev_stuck, exp_mis, accepted, responded;
  int          delay, consumed;

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    m0.imem_req_ready = 1'b0; m0.imem_resp_valid = 1'b0; m0.imem_resp_data = '0;
    m1.imem_req_ready = 1'b0; m1.imem_resp_valid = 1'b0; m1.imem_resp_data = '0;
    tick(); tick();
    chk("reset_if_valid", 32'(if_valid0), 32'd0);
    chk("reset_instr", instruction0, NOP_INSTR);
    chk("reset_if_pc", if_pc0, 32'h0);
    chk("reset_misaligned", 32'(misaligned0), 32'd0);

    // first fetch, best-case latency; dut1 checks PC wrap from 0xFFFFFFFC
    reset = 1'b1; m0.imem_req_ready = 1'b1; m1.imem_req_ready = 1'b1;
    neg();
    chk("t1_req_valid", 32'(m0.imem_req_valid), 32'd1);
    chk("t1_req_addr", m0.imem_req_addr, 32'h0);
    chk("wrap_first_addr", m1.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    m0.imem_req_ready = 1'b0; m0.imem_resp_valid = 1'b1; m0.imem_resp_data = 32'h0050_0093;
    m1.imem_req_ready = 1'b0; m1.imem_resp_valid = 1'b1; m1.imem_resp_data = 32'h0000_0013;
    neg();
    chk("t1_no_req_in_wait", 32'(m0.imem_req_valid), 32'd0);
    tick();
    m0.imem_resp_valid = 1'b0; m1.imem_resp_valid = 1'b0;
    chk("t1_if_valid", 32'(if_valid0), 32'd1);
    chk("t1_instr", instruction0, 32'h0050_0093);
    chk("t1_if_pc", if_pc0, 32'h0);

    // stall while the next response arrives: it must park in the skid buffer
    stall = 1'b1; m0.imem_req_ready = 1'b1;
    neg();
    chk("t1_next_addr", m0.imem_req_addr, 32'h4);
    chk("wrap_second_addr", m1.imem_req_addr, 32'h0);
    chk("wrap_second_valid", 32'(m1.imem_req_valid), 32'd1);
    tick();
    m0.imem_req_ready = 1'b0; m0.imem_resp_valid = 1'b1; m0.imem_resp_data = 32'h0010_0113;
    tick();
    m0.imem_resp_valid = 1'b0;
    chk("t2_hold_instr", instruction0, 32'h0050_0093);
    chk("t2_hold_if_pc", if_pc0, 32'h0);
    neg();
    chk("t2_no_req", 32'(m0.imem_req_valid), 32'd0);
    tick();
    stall = 1'b0;
    neg();
    chk("t2_no_req_late", 32'(m0.imem_req_valid), 32'd0);
    chk("t2_hold_instr_late", instruction0, 32'h0050_0093);
    tick();
    chk("t2_unload_instr", instruction0, 32'h0010_0113);
    chk("t2_unload_if_pc", if_pc0, 32'h4);
    chk("t2_unload_valid", 32'(if_valid0), 32'd1);
    neg();
    chk("t2_next_addr", m0.imem_req_addr, 32'h8);

    // redirect while waiting: stale response must vanish
    tick();
    stall = 1'b1; m0.imem_req_ready = 1'b1;
    tick();
    m0.imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("t3_flush_valid", 32'(if_valid0), 32'd0);
    chk("t3_flush_instr", instruction0, NOP_INSTR);
    chk("t3_aligned_no_pulse", 32'(misaligned0), 32'd0);
    neg();
    chk("t3_drop_no_req", 32'(m0.imem_req_valid), 32'd0);
    tick();
    m0.imem_resp_valid = 1'b1; m0.imem_resp_data = 32'hDEAD_BEEF;
    tick();
    m0.imem_resp_valid = 1'b0;
    chk("t3_stale_dropped", instruction0, NOP_INSTR);
    chk("t3_stale_not_valid", 32'(if_valid0), 32'd0);
    neg();
    chk("t3_req_after_drop", 32'(m0.imem_req_valid), 32'd1);
    chk("t3_redirect_addr", m0.imem_req_addr, 32'h100);

    // misaligned redirect target
    tick();
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    chk("t4_misaligned_pulse", 32'(misaligned0), 32'd1);
    neg();
    chk("t4_aligned_addr", m0.imem_req_addr, 32'h100);
    tick();
    chk("t4_pulse_ends", 32'(misaligned0), 32'd0);

    // fill IF/ID and skid, then reset during HOLD
    m0.imem_req_ready = 1'b1;
    tick();
    m0.imem_req_ready = 1'b0; m0.imem_resp_valid = 1'b1; m0.imem_resp_data = 32'h1111_1111;
    tick();
    m0.imem_resp_valid = 1'b0; m0.imem_req_ready = 1'b1;
    chk("t6_load_instr", instruction0, 32'h1111_1111);
    chk("t6_load_if_pc", if_pc0, 32'h100);
    tick();
    m0.imem_req_ready = 1'b0; m0.imem_resp_valid = 1'b1; m0.imem_resp_data = 32'h2222_2222;
    tick();
    m0.imem_resp_valid = 1'b0;
    chk("t6_hold_instr", instruction0, 32'h1111_1111);
    neg();
    chk("t6_hold_no_req", 32'(m0.imem_req_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("t6_reset_valid", 32'(if_valid0), 32'd0);
    chk("t6_reset_instr", instruction0, NOP_INSTR);
    reset = 1'b1; stall = 1'b0;
    neg();
    chk("t6_reset_addr", m0.imem_req_addr, 32'h0);
    chk("t6_reset_req_valid", 32'(m0.imem_req_valid), 32'd1);
    tick();
    chk("t6_skid_cleared", 32'(if_valid0), 32'd0);

    // randomized run against the sequential instruction-stream model
    exp_pc = 32'h0; pending = 1'b0; delay = 0; prev_stuck = 1'b0; prev_addr = '0;
    exp_mis = 1'b0; consumed = 0; pend_addr = '0;
    for (int i = 0; i < 3000; i++) begin
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 39) == 0);
      r = $urandom;
      redirect_pc = {18'h0, r[13:0]};
      m0.imem_req_ready = ($urandom_range(0, 9) < 7);
      if (pending && delay == 0) begin
        m0.imem_resp_valid = 1'b1;
        m0.imem_resp_data  = memw(pend_addr);
      end else begin
        m0.imem_resp_valid = 1'b0;
        m0.imem_resp_data  = $urandom;
      end
      neg();
      chk("rnd_misaligned", 32'(misaligned0), 32'(exp_mis));
      if (!if_valid0) chk("rnd_empty_is_nop", instruction0, NOP_INSTR);
      if (pending) chk("rnd_single_outstanding", 32'(m0.imem_req_valid), 32'd0);
      if (prev_stuck) begin
        chk("rnd_req_held", 32'(m0.imem_req_valid), 32'd1);
        chk("rnd_addr_stable", m0.imem_req_addr, prev_addr);
      end
      if (if_valid0 && !stall && !redirect) begin
        chk("rnd_if_pc", if_pc0, exp_pc);
        chk("rnd_instr", instruction0, memw(exp_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
      exp_mis    = redirect && (redirect_pc[1:0] != 2'b00);
      accepted   = m0.imem_req_valid && m0.imem_req_ready;
      prev_stuck = m0.imem_req_valid && !m0.imem_req_ready && !redirect;
      prev_addr  = m0.imem_req_addr;
      responded  = m0.imem_resp_valid;
      tick();
      if (responded) pending = 1'b0;
      else if (pending) delay--;
      if (accepted) begin
        pending   = 1'b1;
        pend_addr = prev_addr;
        delay     = $urandom_range(0, 2);
      end
    end
    chk("rnd_progress", 32'(consumed > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
